inert_rd_seq: RTL and testbench
===============================

Name: inert_rd_seq

Overview:
- Producer-side front end for the heading integrator: configures the gyro over SPI after power-up, then services every gyro data-ready interrupt.
- On each interrupt, reads the Z-axis rate low and high bytes through the existing SPI monarch (wrt/cmd/done/resp handshake).
- Presents the assembled signed 16-bit yaw rate with a single-cycle vld strobe. The integrator consumes these as vld/yaw_rt.

Parameters:
- FAST_SIM, 1, shortens the power-up wait: 1 → wait until timer == 16'h000F; 0 → wait until timer == 16'hFFFF.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- INT  input  1  gyro data-ready interrupt, asynchronous, active high, level held until the high byte is read
- done  input  1  SPI monarch transaction-complete pulse, one clock
- resp  input  16  SPI monarch returned word; data byte in resp[7:0], valid in the cycle done is high
- wrt  output  1  one-clock pulse starting an SPI transaction
- cmd  output  16  SPI command word, registered, held stable from wrt until done
- vld  output  1  one-clock strobe: new yaw_rt available
- yaw_rt  output  16  signed yaw rate {high byte, low byte}

Behaviour:
- Reset values (asynchronous): state=PWR_WAIT, timer=0, wrt=0, cmd=16'h0000, vld=0, yaw_rt=16'h0000, low-byte holding register=8'h00, INT sync flops=0.
- INT passes through a 2-flop synchronizer. Only the synchronized version (INT_s) is used.
- timer: 16-bit up counter, counting only in PWR_WAIT.
- Command issue rule: when entering a command state, in the same registered update set wrt=1 and load cmd.
  - Next cycle wrt=0; cmd holds.
  - Remain in the state until done=1. Exactly one wrt per command. done arriving in any non-command state is ignored.
- States and transitions:
  - PWR_WAIT: count timer; at terminal value (per FAST_SIM) → INIT1.
  - INIT1: cmd=16'h0D02 (route gyro data-ready to INT); done → INIT2.
  - INIT2: cmd=16'h1160 (gyro ODR 416 Hz, ±250 dps); done → INIT3.
  - INIT3: cmd=16'h1440 (rounding enable); done → WAIT_INT.
  - WAIT_INT: if INT_s=1 → RD_L; else stay.
  - RD_L: cmd=16'hA600 (read OUTZ_L_G); on done capture resp[7:0] into the low register → RD_H.
  - RD_H: cmd=16'hA700 (read OUTZ_H_G); on done → VLD.
  - VLD: set yaw_rt={resp_H,low} and vld=1 for this one cycle → WAIT_INT.
    - resp_H is latched at the done of RD_H.
    - yaw_rt holds until the next VLD.
- Latency: vld rises exactly 1 clock after the done pulse that ends RD_H. The minimum interrupt-to-vld delay is 2 sync clocks + 2 SPI transactions + 2 clocks.
- INT asserted during PWR_WAIT/INIT*: ignored. It is serviced once WAIT_INT is reached if still high.
- INT still high (stale synchronizer level) on return to WAIT_INT: a new read is started. This is acceptable because the gyro keeps INT high only while the data is unread.
- A bench holding INT high continuously gets back-to-back read pairs with vld at each VLD.
- Reset mid-transaction (any state): immediate return to the reset values above. wrt never glitches high during reset, and init restarts from PWR_WAIT.
- No arithmetic on the data: bytes are concatenated verbatim, and the sign comes from the high byte bit 7.

Test Plan:
- Reset release, FAST_SIM=1, done tied 0: exactly 16 cycles in PWR_WAIT, then a single wrt pulse with cmd=16'h0D02; cmd holds and no further wrt occurs.
- Init sequence with a model responding to each wrt with done 20 clocks later: cmd sequence 0D02, 1160, 1440 with exactly three wrt pulses, then idle in WAIT_INT with wrt=0 and vld=0.
- After init, raise INT with the model returning resp=16'h00F0 then 16'h00FF: cmds A600, A700; vld high for exactly 1 cycle, 1 clock after the second done; yaw_rt=16'hFFF0 (-16); yaw_rt holds after vld drops.
- INT held high continuously with alternating data pairs (34/12 then CD/AB): consecutive vld pulses with yaw_rt=16'h1234 then 16'hABCD; each pair is exactly one A600 followed by one A700.
- INT pulsed high during INIT2 then low before WAIT_INT: no A600 is ever issued, and vld stays 0.
- rst_n asserted while in RD_H with cmd=A700 pending: wrt/vld/yaw_rt/cmd go to 0 immediately. After release, the full PWR_WAIT + init sequence repeats before any read.

Source files
------------

// File: rtl/inert_rd_seq_if.sv
// Gyro front-end bus: interrupt and SPI monarch handshake in, yaw-rate strobe out.
// The master side is the sequencer; the slave side is the gyro/SPI/integrator environment.
interface inert_rd_seq_if;
    logic        INT;
    logic        done;
    logic [15:0] resp;
    logic        wrt;
    logic [15:0] cmd;
    logic        vld;
    logic [15:0] yaw_rt;

    modport master (
        input  INT,
        input  done,
        input  resp,
        output wrt,
        output cmd,
        output vld,
        output yaw_rt
    );

    modport slave (
        output INT,
        output done,
        output resp,
        input  wrt,
        input  cmd,
        input  vld,
        input  yaw_rt
    );
endinterface

// File: rtl/inert_rd_seq.sv
// Gyro front end: configures the gyro over SPI after power-up, then reads the
// Z-axis rate bytes on every data-ready interrupt and presents them with a vld strobe.
module inert_rd_seq #(
    parameter bit FAST_SIM = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    inert_rd_seq_if.master bus
);
    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT1,
        INIT2,
        INIT3,
        WAIT_INT,
        RD_L,
        RD_H,
        VLD
    } state_t;

    localparam logic [15:0] TIMER_TERM = FAST_SIM ? 16'h000F : 16'hFFFF;
    localparam logic [15:0] CMD_INIT1  = 16'h0D02;
    localparam logic [15:0] CMD_INIT2  = 16'h1160;
    localparam logic [15:0] CMD_INIT3  = 16'h1440;
    localparam logic [15:0] CMD_RD_L   = 16'hA600;
    localparam logic [15:0] CMD_RD_H   = 16'hA700;

    state_t      state, state_nxt;
    logic [15:0] timer, timer_nxt;
    logic        int_meta, int_s;
    logic        wrt_q, wrt_nxt;
    logic [15:0] cmd_q, cmd_nxt;
    logic        vld_q, vld_nxt;
    logic [15:0] yaw_q, yaw_nxt;
    logic [7:0]  low_q, low_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta <= 1'b0;
            int_s    <= 1'b0;
        end else begin
            int_meta <= bus.INT;
            int_s    <= int_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PWR_WAIT;
            timer <= 16'h0000;
            wrt_q <= 1'b0;
            cmd_q <= 16'h0000;
            vld_q <= 1'b0;
            yaw_q <= 16'h0000;
            low_q <= 8'h00;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            wrt_q <= wrt_nxt;
            cmd_q <= cmd_nxt;
            vld_q <= vld_nxt;
            yaw_q <= yaw_nxt;
            low_q <= low_nxt;
        end
    end

    // wrt and cmd are loaded on the edge that enters a command state, so the
    // transaction starts in that state's first cycle and cmd holds until done.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        wrt_nxt   = 1'b0;
        cmd_nxt   = cmd_q;
        vld_nxt   = 1'b0;
        yaw_nxt   = yaw_q;
        low_nxt   = low_q;
        case (state)
            PWR_WAIT: begin
                if (timer == TIMER_TERM) begin
                    state_nxt = INIT1;
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_INIT1;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            INIT1: begin
                if (bus.done) begin
                    state_nxt = INIT2;
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_INIT2;
                end
            end
            INIT2: begin
                if (bus.done) begin
                    state_nxt = INIT3;
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_INIT3;
                end
            end
            INIT3: begin
                if (bus.done) begin
                    state_nxt = WAIT_INT;
                end
            end
            WAIT_INT: begin
                if (int_s) begin
                    state_nxt = RD_L;
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_RD_L;
                end
            end
            RD_L: begin
                if (bus.done) begin
                    low_nxt   = bus.resp[7:0];
                    state_nxt = RD_H;
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CMD_RD_H;
                end
            end
            // The high byte is folded into yaw_rt at its done, so yaw_rt and vld
            // are both valid throughout the single VLD cycle.
            RD_H: begin
                if (bus.done) begin
                    yaw_nxt   = {bus.resp[7:0], low_q};
                    vld_nxt   = 1'b1;
                    state_nxt = VLD;
                end
            end
            VLD: begin
                state_nxt = WAIT_INT;
            end
            default: begin
                state_nxt = PWR_WAIT;
            end
        endcase
    end

    assign bus.wrt    = wrt_q;
    assign bus.cmd    = cmd_q;
    assign bus.vld    = vld_q;
    assign bus.yaw_rt = yaw_q;
endmodule

// File: tb/tb_inert_rd_seq.sv
// Randomised bench for inert_rd_seq: an SPI responder plus a transaction-level model
// of the expected command stream, vld timing and yaw value, checked every cycle.
module tb_inert_rd_seq;
    logic clk;
    logic rst_n;

    inert_rd_seq_if bus ();

    inert_rd_seq #(
        .FAST_SIM(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state: what the spec says must come out, tracked per transaction.
    logic [15:0] init_cmds [3] = '{16'h0D02, 16'h1160, 16'h1440};
    int          init_idx = 0;
    bit          rd_phase = 1'b0;
    bit          pending = 1'b0;
    int          delay_left = 0;
    logic [15:0] pend_cmd = 16'h0000;
    int          cyc = 0;
    bit          first_wrt_seen = 1'b0;
    bit          exp_vld = 1'b0;
    logic [15:0] model_yaw = 16'h0000;
    logic [7:0]  model_lo = 8'h00;
    int          wrt_cnt = 0;
    int          a600_cnt = 0;
    int          vld_cnt = 0;
    logic [15:0] yaw_log [$];
    logic [7:0]  byte_q [$];
    int          resp_delay = 1000;
    bit          spurious_en = 1'b0;
    logic [3:0]  int_hist = 4'h0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("[TB] FAIL timeout_%s: condition not reached within budget at %0t", name, $time);
    endtask

    function automatic logic [15:0] logged_yaw(input int i);
        if (i < yaw_log.size()) return yaw_log[i];
        return 16'hxxxx;
    endfunction

    // Monitor, model and SPI responder in one negedge process so ordering is fixed.
    initial begin
        logic [15:0] exp_cmd;
        logic [7:0]  b;
        bus.done = 1'b0;
        bus.resp = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check_output("rst_wrt", {31'd0, bus.wrt}, 32'd0);
                check_output("rst_vld", {31'd0, bus.vld}, 32'd0);
                check_output("rst_cmd", {16'd0, bus.cmd}, 32'd0);
                check_output("rst_yaw", {16'd0, bus.yaw_rt}, 32'd0);
                init_idx = 0; rd_phase = 1'b0; pending = 1'b0; cyc = 0;
                first_wrt_seen = 1'b0; exp_vld = 1'b0; model_yaw = 16'h0000; model_lo = 8'h00;
                wrt_cnt = 0; a600_cnt = 0; vld_cnt = 0; int_hist = 4'h0;
                yaw_log.delete();
                bus.done = 1'b0;
                bus.resp = 16'($urandom);
            end else begin
                cyc++;
                int_hist = {int_hist[2:0], bus.INT};
                check_output("vld", {31'd0, bus.vld}, {31'd0, exp_vld});
                check_output("yaw_rt", {16'd0, bus.yaw_rt}, {16'd0, model_yaw});
                if (bus.vld) begin
                    vld_cnt++;
                    yaw_log.push_back(bus.yaw_rt);
                end
                exp_vld  = 1'b0;
                bus.done = 1'b0;
                bus.resp = 16'($urandom);
                if (bus.wrt) begin
                    wrt_cnt++;
                    check_output("wrt_while_busy", {31'd0, pending}, 32'd0);
                    if (!first_wrt_seen) begin
                        first_wrt_seen = 1'b1;
                        check_output("pwr_wait_len", cyc, 32'd16);
                    end
                    if (init_idx < 3) begin
                        exp_cmd = init_cmds[init_idx];
                        init_idx++;
                    end else begin
                        exp_cmd = rd_phase ? 16'hA700 : 16'hA600;
                        if (!rd_phase) begin
                            a600_cnt++;
                            check_output("read_without_int", {31'd0, |int_hist}, 32'd1);
                        end
                        rd_phase = !rd_phase;
                    end
                    check_output("cmd_issue", {16'd0, bus.cmd}, {16'd0, exp_cmd});
                    pending    = 1'b1;
                    pend_cmd   = exp_cmd;
                    delay_left = (resp_delay > 0) ? resp_delay : int'($urandom_range(1, 12));
                end else if (pending) begin
                    check_output("cmd_hold", {16'd0, bus.cmd}, {16'd0, pend_cmd});
                    delay_left--;
                    if (delay_left == 0) begin
                        pending  = 1'b0;
                        bus.done = 1'b1;
                        if (pend_cmd == 16'hA600 || pend_cmd == 16'hA700) begin
                            b = (byte_q.size() > 0) ? byte_q.pop_front() : 8'($urandom);
                            bus.resp = {8'($urandom), b};
                            if (pend_cmd == 16'hA600) begin
                                model_lo = b;
                            end else begin
                                exp_vld   = 1'b1;
                                model_yaw = {b, model_lo};
                            end
                        end
                    end
                end
                if (!pending && spurious_en && $urandom_range(0, 19) == 0) begin
                    bus.done = 1'b1;
                end
            end
        end
    end

    task automatic set_int(input logic v);
        @(posedge clk);
        #3 bus.INT = v;
    endtask

    task automatic apply_stimulus_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_init_done(input int budget);
        int t = 0;
        while (!(init_idx == 3 && !pending) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) timeout("init_done");
    endtask

    task automatic wait_a600(input int target, input int budget);
        int t = 0;
        while (a600_cnt < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) timeout("a600");
    endtask

    task automatic wait_vld(input int target, input int budget);
        int t = 0;
        while (vld_cnt < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) timeout("vld");
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.INT = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        // Responder never answers: one INIT1 write after 16 power-up cycles, then nothing.
        repeat (60) @(negedge clk);
        check_output("stall_wrt_count", wrt_cnt, 32'd1);
        check_output("stall_cmd", {16'd0, bus.cmd}, 32'h0D02);
        check_output("stall_wrt_low", {31'd0, bus.wrt}, 32'd0);

        // Full init with done 20 clocks after each write.
        resp_delay = 20;
        apply_stimulus_reset();
        wait_init_done(200);
        repeat (30) @(negedge clk);
        check_output("init_wrt_count", wrt_cnt, 32'd3);
        check_output("init_vld_count", vld_cnt, 32'd0);
        check_output("idle_wrt", {31'd0, bus.wrt}, 32'd0);

        // Single read: low F0, high FF gives -16.
        byte_q = '{8'hF0, 8'hFF};
        set_int(1'b1);
        wait_a600(1, 50);
        set_int(1'b0);
        wait_vld(1, 100);
        repeat (10) @(negedge clk);
        check_output("neg_yaw", {16'd0, logged_yaw(0)}, 32'hFFF0);
        check_output("neg_yaw_hold", {16'd0, bus.yaw_rt}, 32'hFFF0);
        check_output("single_read_count", a600_cnt, 32'd1);
        check_output("single_vld_count", vld_cnt, 32'd1);

        // INT held high: back-to-back read pairs.
        byte_q = '{8'h34, 8'h12, 8'hCD, 8'hAB};
        set_int(1'b1);
        wait_a600(3, 300);
        set_int(1'b0);
        wait_vld(3, 200);
        repeat (10) @(negedge clk);
        check_output("b2b_yaw0", {16'd0, logged_yaw(1)}, 32'h1234);
        check_output("b2b_yaw1", {16'd0, logged_yaw(2)}, 32'hABCD);

        // INT pulse during INIT2 that is gone before WAIT_INT.
        apply_stimulus_reset();
        begin
            int t = 0;
            while (init_idx < 2 && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) timeout("init2");
        end
        set_int(1'b1);
        repeat (4) @(negedge clk);
        set_int(1'b0);
        wait_init_done(200);
        repeat (40) @(negedge clk);
        check_output("early_int_a600", a600_cnt, 32'd0);
        check_output("early_int_vld", vld_cnt, 32'd0);

        // Reset while the high-byte read is outstanding.
        byte_q = '{8'h78, 8'h56};
        set_int(1'b1);
        wait_a600(1, 50);
        set_int(1'b0);
        wait_vld(1, 100);
        check_output("pre_rst_yaw", {16'd0, logged_yaw(0)}, 32'h5678);
        set_int(1'b1);
        begin
            int t = 0;
            while (!(a600_cnt == 2 && pending && pend_cmd == 16'hA700) && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) timeout("rd_h");
        end
        repeat (5) @(negedge clk);
        check_output("rd_h_cmd", {16'd0, bus.cmd}, 32'hA700);
        @(posedge clk);
        #3 rst_n = 1'b0;
        bus.INT = 1'b0;
        #1;
        check_output("async_rst_wrt", {31'd0, bus.wrt}, 32'd0);
        check_output("async_rst_vld", {31'd0, bus.vld}, 32'd0);
        check_output("async_rst_cmd", {16'd0, bus.cmd}, 32'd0);
        check_output("async_rst_yaw", {16'd0, bus.yaw_rt}, 32'd0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_init_done(200);
        repeat (20) @(negedge clk);
        check_output("reinit_wrt_count", wrt_cnt, 32'd3);
        check_output("reinit_a600", a600_cnt, 32'd0);

        // Random phase: random INT, random SPI latency, stray done pulses, occasional reset.
        resp_delay  = 0;
        spurious_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 14) == 0) begin
                apply_stimulus_reset();
            end
            set_int(1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 60)) @(negedge clk);
        end
        spurious_en = 1'b0;
        set_int(1'b0);
        repeat (80) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got time %0t, expected below 500000", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
